branch_predictor: RTL and testbench

//  Fetch-stage branch target buffer (BTB) with 2-bit saturating counters.

---
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor.sv | 122 ++++++++++++
 tb/tb_branch_predictor.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-resolution signal bundle for branch_predictor.
// master drives fetch/resolve inputs; slave is the predictor itself.
interface branch_predictor_if;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        res_valid;
  logic        res_stall;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic [0:3]  flushes;  // {ifid, idex, exmem, memwb}

  modport master (
    output fetch_pc, res_valid, res_stall, res_pc, res_taken, res_target,
           res_pred_taken, res_pred_target,
    input  pred_taken, pred_target, redirect, redirect_pc, flushes
  );

  modport slave (
    input  fetch_pc, res_valid, res_stall, res_pc, res_taken, res_target,
           res_pred_taken, res_pred_target,
    output pred_taken, pred_target, redirect, redirect_pc, flushes
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; combinational lookup and redirect.
// Optional BP_STATS_EN adds resolved-branch and mispredict counters as outputs.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  branch_predictor_if.slave bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]             valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [ENTRIES-1:0][31:0]       target_q, target_d;
  logic [ENTRIES-1:0][1:0]        ctr_q, ctr_d;

  logic [IDX_W-1:0] f_idx, r_idx;
  logic [TAG_W-1:0] f_tag, r_tag;
  logic             f_hit, r_hit;
  logic             act, mis;
  logic [31:0]      actual_npc;

  // Low PC bits are always zero for word-aligned fetch; res_pred_taken is
  // redundant with res_pred_target for mispredict detection.
  logic unused_bits;
  assign unused_bits = ^{bp.fetch_pc[1:0], bp.res_pc[1:0], bp.res_pred_taken};

  // Lookup
  assign f_idx = bp.fetch_pc[IDX_W+1:2];
  assign f_tag = bp.fetch_pc[31:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  always_comb begin
    bp.pred_taken  = f_hit && ctr_q[f_idx][1];
    bp.pred_target = bp.pred_taken ? target_q[f_idx] : bp.fetch_pc + 32'd4;
  end

  // Resolution
  assign r_idx      = bp.res_pc[IDX_W+1:2];
  assign r_tag      = bp.res_pc[31:IDX_W+2];
  assign r_hit      = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign act        = bp.res_valid && !bp.res_stall;
  assign actual_npc = bp.res_taken ? bp.res_target : bp.res_pc + 32'd4;
  // Comparing full next-PC catches both wrong direction and wrong target.
  assign mis        = act && (bp.res_pred_target != actual_npc);

  always_comb begin
    bp.redirect    = mis;
    bp.redirect_pc = actual_npc;
    bp.flushes     = mis ? 4'b1100 : 4'b0000;
  end

  // Training
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (act) begin
      if (r_hit) begin
        if (bp.res_taken) begin
          if (ctr_q[r_idx] != 2'b11) begin
            ctr_d[r_idx] = ctr_q[r_idx] + 2'd1;
          end
          target_d[r_idx] = bp.res_target;
        end else if (ctr_q[r_idx] != 2'b00) begin
          ctr_d[r_idx] = ctr_q[r_idx] - 2'd1;
        end
      end else if (bp.res_taken) begin
        valid_d[r_idx]  = 1'b1;
        tag_d[r_idx]    = r_tag;
        target_d[r_idx] = bp.res_target;
        ctr_d[r_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= {ENTRIES{2'b01}};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q + {31'd0, act};
    stat_mispredicts_d = stat_mispredicts_q + {31'd0, mis};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic against a table-level reference model. Define BP_STATS_EN to cover the counters.
module tb_branch_predictor;
  localparam int unsigned Entries = 16;
  localparam int unsigned IdxW    = 4;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  branch_predictor_if bp ();
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_predictor #(.ENTRIES(Entries)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bp   (bp)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one record per BTB slot, plus statistics.
  bit          m_valid [Entries];
  logic [31:0] m_tag   [Entries];
  logic [31:0] m_target[Entries];
  int          m_ctr   [Entries];
  int          m_br;
  int          m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % Entries);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IdxW + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit exp_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] pc);
    return exp_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] exp_npc();
    return bp.res_taken ? bp.res_target : bp.res_pc + 32'd4;
  endfunction

  function automatic bit exp_act();
    return bp.res_valid && !bp.res_stall;
  endfunction

  function automatic bit exp_mis();
    return exp_act() && (bp.res_pred_target != exp_npc());
  endfunction

  task automatic m_reset();
    for (int i = 0; i < Entries; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = '0;
      m_target[i] = '0;
      m_ctr[i]    = 1;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic m_train();
    int i;
    i = idx_of(bp.res_pc);
    if (m_hit(bp.res_pc)) begin
      if (bp.res_taken) begin
        m_ctr[i]    = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_target[i] = bp.res_target;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (bp.res_taken) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = tag_of(bp.res_pc);
      m_target[i] = bp.res_target;
      m_ctr[i]    = 2;
    end
  endtask

  task automatic drive(input logic [31:0] fpc, input logic rv, input logic rs,
                       input logic [31:0] rpc, input logic rt, input logic [31:0] rtgt,
                       input logic [31:0] rptgt);
    bp.fetch_pc        = fpc;
    bp.res_valid       = rv;
    bp.res_stall       = rs;
    bp.res_pc          = rpc;
    bp.res_taken       = rt;
    bp.res_target      = rtgt;
    bp.res_pred_target = rptgt;
    bp.res_pred_taken  = (rptgt != rpc + 32'd4);
    #1;
  endtask

  // Advance one clock; the model sees the same pre-edge inputs the DUT does.
  task automatic tick();
    @(posedge CLK);
    if (nRST) begin
      if (exp_act()) m_br++;
      if (exp_mis()) m_mis++;
      if (exp_act()) m_train();
    end
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    m_reset();
    drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    checks++; if (bp.pred_taken !== 1'b0) begin errors++;
      $display("FAIL reset_pred_taken: got %b want 0", bp.pred_taken); end
    checks++; if (bp.pred_target !== 32'h44) begin errors++;
      $display("FAIL reset_pred_target: got %h want 00000044", bp.pred_target); end
    checks++; if (bp.redirect !== 1'b0) begin errors++;
      $display("FAIL reset_redirect: got %b want 0", bp.redirect); end
    checks++; if (bp.flushes !== 4'b0000) begin errors++;
      $display("FAIL reset_flushes: got %b want 0000", bp.flushes); end
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_train_redirect();
    drive(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h100, 32'h44);
    checks++; if (bp.redirect !== 1'b1) begin errors++;
      $display("FAIL alloc_redirect: got %b want 1", bp.redirect); end
    checks++; if (bp.redirect_pc !== 32'h100) begin errors++;
      $display("FAIL alloc_redirect_pc: got %h want 00000100", bp.redirect_pc); end
    checks++; if (bp.flushes !== 4'b1100) begin errors++;
      $display("FAIL alloc_flushes: got %b want 1100", bp.flushes); end
    checks++; if (bp.pred_taken !== 1'b0) begin errors++;
      $display("FAIL alloc_no_bypass: got %b want 0", bp.pred_taken); end
    tick();
    drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    checks++; if (bp.pred_taken !== 1'b1) begin errors++;
      $display("FAIL alloc_hit_taken: got %b want 1", bp.pred_taken); end
    checks++; if (bp.pred_target !== 32'h100) begin errors++;
      $display("FAIL alloc_hit_target: got %h want 00000100", bp.pred_target); end
  endtask

  task automatic test_ctr_saturate();
    drive(32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 32'h100);
    checks++; if (bp.redirect !== 1'b1 || bp.redirect_pc !== 32'h44) begin errors++;
      $display("FAIL nt1_redirect: got %b/%h want 1/00000044", bp.redirect, bp.redirect_pc); end
    tick();
    drive(32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 32'h44);
    checks++; if (bp.pred_taken !== 1'b0) begin errors++;
      $display("FAIL nt1_pred_taken: got %b want 0", bp.pred_taken); end
    checks++; if (bp.redirect !== 1'b0 || bp.flushes !== 4'b0000) begin errors++;
      $display("FAIL nt2_no_redirect: got %b/%b want 0/0000", bp.redirect, bp.flushes); end
    tick();
    // Counter now at 00: one taken must leave it below the taken threshold.
    drive(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h120, 32'h44);
    tick();
    drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    checks++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h44) begin errors++;
      $display("FAIL sat_low: got %b/%h want 0/00000044", bp.pred_taken, bp.pred_target); end
    drive(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h120, 32'h44);
    tick();
    drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    checks++; if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h120) begin errors++;
      $display("FAIL retrain: got %b/%h want 1/00000120", bp.pred_taken, bp.pred_target); end
  endtask

  task automatic test_alias();
    drive(32'h80, 1'b1, 1'b0, 32'h80, 1'b1, 32'h500, 32'h84);
    tick();
    drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    checks++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h44) begin errors++;
      $display("FAIL alias_evicted: got %b/%h want 0/00000044", bp.pred_taken, bp.pred_target); end
    drive(32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    checks++; if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h500) begin errors++;
      $display("FAIL alias_new_hit: got %b/%h want 1/00000500", bp.pred_taken, bp.pred_target); end
    // Not-taken miss at the same index must not allocate.
    drive(32'h80, 1'b1, 1'b0, 32'hC0, 1'b0, 32'h0, 32'hC4);
    tick();
    drive(32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    checks++; if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h500) begin errors++;
      $display("FAIL nt_no_alloc: got %b/%h want 1/00000500", bp.pred_taken, bp.pred_target); end
  endtask

  task automatic test_stall();
    drive(32'h208, 1'b1, 1'b1, 32'h208, 1'b1, 32'h300, 32'h20C);
    checks++; if (bp.redirect !== 1'b0 || bp.flushes !== 4'b0000) begin errors++;
      $display("FAIL stall_redirect: got %b/%b want 0/0000", bp.redirect, bp.flushes); end
    tick();
    checks++; if (bp.pred_taken !== 1'b0) begin errors++;
      $display("FAIL stall_no_train: got %b want 0", bp.pred_taken); end
    drive(32'h208, 1'b1, 1'b0, 32'h208, 1'b1, 32'h300, 32'h20C);
    checks++; if (bp.redirect !== 1'b1 || bp.redirect_pc !== 32'h300) begin errors++;
      $display("FAIL unstall_redirect: got %b/%h want 1/00000300", bp.redirect, bp.redirect_pc); end
    tick();
    drive(32'h208, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    checks++; if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h300) begin errors++;
      $display("FAIL unstall_train: got %b/%h want 1/00000300", bp.pred_taken, bp.pred_target); end
  endtask

  task automatic test_wrap();
    drive(32'hFFFF_FFFC, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    checks++; if (bp.pred_target !== 32'h0) begin errors++;
      $display("FAIL wrap_pred_target: got %h want 00000000", bp.pred_target); end
    checks++; if (bp.redirect !== 1'b0 || bp.redirect_pc !== 32'h0) begin errors++;
      $display("FAIL wrap_redirect: got %b/%h want 0/00000000", bp.redirect, bp.redirect_pc); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(32'h208, 1'b1, 1'b0, 32'h44, 1'b1, 32'h700, 32'h48);
    #2;
    nRST = 1'b0;
    #1;
    checks++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h20C) begin errors++;
      $display("FAIL midreset_clear: got %b/%h want 0/0000020C", bp.pred_taken, bp.pred_target); end
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    m_reset();
    drive(32'h44, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    checks++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h48) begin errors++;
      $display("FAIL midreset_no_partial: got %b/%h want 0/00000048", bp.pred_taken,
               bp.pred_target); end
    @(posedge CLK);
    #1;
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    drive(32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 32'h44);
    tick();
    drive(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h100, 32'h44);
    tick();
    drive(32'h40, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 32'h100);
    tick();
    drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    checks++; if (stat_branches !== 32'd3 || stat_mispredicts !== 32'd2) begin errors++;
      $display("FAIL stats_count: got %0d/%0d want 3/2", stat_branches, stat_mispredicts); end
    nRST = 1'b0;
    #1;
    checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin errors++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
    @(negedge CLK);
    nRST = 1'b1;
    m_reset();
    @(posedge CLK);
    #1;
  endtask
`endif

  function automatic logic [31:0] rand_pc();
    logic [31:0] idx;
    idx = 32'($urandom_range(0, Entries - 1)) << 2;
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFC0 | idx;
    return (32'($urandom_range(0, 3)) << (IdxW + 2)) | idx;
  endfunction

  task automatic test_random();
    logic [31:0] rpc, rptgt;
    for (int n = 0; n < 600; n++) begin
      rpc   = rand_pc();
      rptgt = ($urandom_range(0, 3) != 0) ? exp_target(rpc) : rand_pc();
      drive(rand_pc(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0), rpc,
            1'($urandom_range(0, 1)), rand_pc(), rptgt);
      checks++; if (bp.pred_taken !== exp_taken(bp.fetch_pc)) begin errors++;
        $display("FAIL rnd_pred_taken pc=%h: got %b want %b", bp.fetch_pc, bp.pred_taken,
                 exp_taken(bp.fetch_pc)); end
      checks++; if (bp.pred_target !== exp_target(bp.fetch_pc)) begin errors++;
        $display("FAIL rnd_pred_target pc=%h: got %h want %h", bp.fetch_pc, bp.pred_target,
                 exp_target(bp.fetch_pc)); end
      checks++; if (bp.redirect !== exp_mis()) begin errors++;
        $display("FAIL rnd_redirect: got %b want %b", bp.redirect, exp_mis()); end
      checks++; if (bp.redirect_pc !== exp_npc()) begin errors++;
        $display("FAIL rnd_redirect_pc: got %h want %h", bp.redirect_pc, exp_npc()); end
      checks++; if (bp.flushes !== (exp_mis() ? 4'b1100 : 4'b0000)) begin errors++;
        $display("FAIL rnd_flushes: got %b want %b", bp.flushes,
                 exp_mis() ? 4'b1100 : 4'b0000); end
      tick();
    end
`ifdef BP_STATS_EN
    checks++; if (stat_branches !== 32'(m_br) || stat_mispredicts !== 32'(m_mis)) begin
      errors++;
      $display("FAIL rnd_stats: got %0d/%0d want %0d/%0d", stat_branches, stat_mispredicts,
               m_br, m_mis); end
`endif
  endtask

  initial begin
    test_reset();
    test_train_redirect();
    test_ctr_saturate();
    test_alias();
    test_stall();
    test_wrap();
    test_reset_mid();
`ifdef BP_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
